ldlt_decomp_nxn: RTL and testbench

//  Parametrised in-place LDL^T factorisation of a symmetric NxN fixed-point matrix (A = L*D*L^T).

---
 rtl/ldlt_decomp_nxn_pkg.sv | 21 ++
 rtl/ldlt_decomp_nxn_loop_ctrl.sv | 90 +++++++++
 rtl/ldlt_decomp_nxn.sv | 180 ++++++++++++++++++
 tb/tb_ldlt_decomp_nxn.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ldlt_decomp_nxn_pkg.sv
// LDL^T factoriser shared types and constants.
// Matrix word format, FSM states, packed lower-triangle index helper.
package ldlt_decomp_nxn_pkg;

  localparam int MATRIX_BW = 32;
  localparam int MUL       = 16;
  localparam int LDLT_N    = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DIV,
    DONE
  } ldlt_state_e;

  function automatic int tri_idx(input int i, input int j);
    return i * (i + 1) / 2 + j;
  endfunction

endpackage

// File: rtl/ldlt_decomp_nxn_loop_ctrl.sv
// LDL^T loop sequencer: column/row/inner indices and per-op phase.
// Ports: i_clk, i_rst_n, i_st (top FSM state); o_i/o_j/o_k indices,
// o_wb (op result ready), o_last (final op), o_nx_div (next op is DIV).
module ldlt_decomp_nxn_loop_ctrl
  import ldlt_decomp_nxn_pkg::*;
#(
  parameter int N       = LDLT_N,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 3,
  parameter int IW      = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  ldlt_state_e   i_st,
  output logic [IW-1:0] o_i,
  output logic [IW-1:0] o_j,
  output logic [IW-1:0] o_k,
  output logic          o_wb,
  output logic          o_last,
  output logic          o_nx_div
);

  localparam int LMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int PHW  = $clog2(LMAX + 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  logic           run;
  logic           div;
  logic [PHW-1:0] ph;
  logic [PHW-1:0] ph_end;
  logic [IW-1:0]  kmax;
  logic [IW-1:0]  i_nx;
  logic [IW-1:0]  j_nx;
  logic [IW-1:0]  k_nx;

  assign div    = i_st == DIV;
  assign run    = div || i_st == MAC;
  assign ph_end = div ? PHW'(DIV_LAT) : PHW'(MUL_LAT);
  assign o_wb   = run && ph == ph_end;
  assign kmax   = o_j - ONE;
  assign o_last = i_st == MAC && o_j == LAST
               && o_i == LAST && o_k == kmax;

  // MAC: k inner, then i; column's MACs are followed by
  // its DIVs (i=j+1..), which lead into next column's MACs.
  always_comb begin
    i_nx     = o_i;
    j_nx     = o_j;
    k_nx     = '0;
    o_nx_div = div;
    if (!div && o_k != kmax) begin
      k_nx = o_k + ONE;
    end else if (!div && o_i != LAST) begin
      i_nx = o_i + ONE;
    end else if (!div) begin
      o_nx_div = 1'b1;
      i_nx     = o_j + ONE;
    end else if (o_i != LAST) begin
      i_nx = o_i + ONE;
    end else begin
      o_nx_div = 1'b0;
      j_nx     = o_j + ONE;
      i_nx     = o_j + ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_i <= '0;
      o_j <= '0;
      o_k <= '0;
      ph  <= '0;
    end else if (i_st == LOAD) begin
      // column 0 has no MACs: first op is DIV(1,0)
      o_i <= ONE;
      o_j <= '0;
      o_k <= '0;
      ph  <= '0;
    end else if (o_wb) begin
      o_i <= i_nx;
      o_j <= j_nx;
      o_k <= k_nx;
      ph  <= '0;
    end else if (run) begin
      ph <= ph + PHW'(1);
    end
  end

endmodule

// File: rtl/ldlt_decomp_nxn.sv
// In-place LDL^T factorisation of a symmetric NxN fixed-point matrix.
// Ports: i_clk, i_rst_n, i_start, i_mat (packed lower triangle);
// o_busy, o_done, o_div_zero (sticky), o_mat (D diag, L below).
// Macro LDLT_SAT_EN: saturate MAC/quotient results instead of wrap.
module ldlt_decomp_nxn
  import ldlt_decomp_nxn_pkg::*;
#(
  parameter int N       = LDLT_N,
  parameter int DW      = MATRIX_BW,
  parameter int FRAC    = MUL,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [N*(N+1)/2*DW-1:0] i_mat,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_div_zero,
  output logic [N*(N+1)/2*DW-1:0] o_mat
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW - FRAC + 1;
  localparam int QW = DW + FRAC;
  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SONE = DW'(1);
  localparam logic signed [PW-1:0] RND  =
    PW'((64'd1 << FRAC) - 64'd1);

  ldlt_state_e st;
  ldlt_state_e st_nx;

  // lower triangle: A -> L/D; upper triangle: W scratch
  logic signed [DW-1:0] m [N][N];

  logic [IW-1:0] ci;
  logic [IW-1:0] cj;
  logic [IW-1:0] ck;
  logic          c_wb;
  logic          c_last;
  logic          c_nx_div;
  logic          dz;

  logic signed [DW-1:0] w_ij;
  logic signed [DW-1:0] w_jj;
  logic signed [DW-1:0] op_w;
  logic signed [DW-1:0] op_l;
  logic signed [DW-1:0] dsor;
  logic signed [DW-1:0] mac_res;
  logic signed [DW-1:0] quo_res;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] prod_o;
  logic signed [PW-1:0] prod_a;
  logic signed [PW-1:0] mul_p [MUL_LAT];
  logic signed [QW-1:0] num;
  logic signed [QW-1:0] den;
  logic signed [QW-1:0] quo_c;
  logic signed [QW-1:0] quo_o;
  logic signed [QW-1:0] div_p [DIV_LAT];
  logic signed [SW-1:0] shf;
  logic signed [SW-1:0] mac_full;

  ldlt_decomp_nxn_loop_ctrl #(
    .N       (N),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .IW      (IW)
  ) u_ctrl (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_st     (st),
    .o_i      (ci),
    .o_j      (cj),
    .o_k      (ck),
    .o_wb     (c_wb),
    .o_last   (c_last),
    .o_nx_div (c_nx_div)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) st <= IDLE;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (i_start) st_nx = LOAD;
      LOAD: st_nx = DIV;
      MAC, DIV: begin
        if (c_wb)
          st_nx = c_last ? DONE : (c_nx_div ? DIV : MAC);
      end
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // W[i][k] lives in the scratch slot (k,i)
  assign w_ij   = m[ci][cj];
  assign w_jj   = m[cj][cj];
  assign op_w   = m[ck][ci];
  assign op_l   = m[cj][ck];
  assign prod_c = op_w * op_l;
  // zero pivot is flagged at writeback; keep the divider defined
  assign dsor   = (w_jj == '0) ? SONE : w_jj;
  assign num    = $signed({w_ij, {FRAC{1'b0}}});
  assign den    = QW'(dsor);
  assign quo_c  = num / den;
  assign prod_o = mul_p[MUL_LAT-1];
  assign quo_o  = div_p[DIV_LAT-1];
  // bias negatives so the arithmetic shift rounds toward zero
  assign prod_a   = prod_o[PW-1] ? prod_o + RND : prod_o;
  assign shf      = SW'(prod_a >>> FRAC);
  assign mac_full = SW'(w_ij) - shf;

`ifdef LDLT_SAT_EN
  localparam logic signed [SW-1:0] S_MAX = SW'(MAXV);
  localparam logic signed [SW-1:0] S_MIN = SW'(MINV);
  localparam logic signed [QW-1:0] Q_MAX = QW'(MAXV);
  localparam logic signed [QW-1:0] Q_MIN = QW'(MINV);
  assign mac_res = (mac_full > S_MAX) ? MAXV :
                   (mac_full < S_MIN) ? MINV : DW'(mac_full);
  assign quo_res = (quo_o > Q_MAX) ? MAXV :
                   (quo_o < Q_MIN) ? MINV : DW'(quo_o);
`else
  logic unused_hi;
  assign unused_hi = ^{mac_full[SW-1:DW], quo_o[QW-1:DW]};
  assign mac_res   = mac_full[DW-1:0];
  assign quo_res   = quo_o[DW-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < MUL_LAT; s++) mul_p[s] <= '0;
      for (int s = 0; s < DIV_LAT; s++) div_p[s] <= '0;
    end else begin
      mul_p[0] <= prod_c;
      div_p[0] <= quo_c;
      for (int s = 1; s < MUL_LAT; s++) mul_p[s] <= mul_p[s-1];
      for (int s = 1; s < DIV_LAT; s++) div_p[s] <= div_p[s-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dz <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          m[r][c] <= '0;
    end else if (st == LOAD) begin
      dz <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c <= r; c++)
          m[r][c] <= i_mat[tri_idx(r, c)*DW +: DW];
    end else if (c_wb && st == MAC) begin
      m[ci][cj] <= mac_res;
    end else if (c_wb && st == DIV) begin
      m[ci][cj] <= (w_jj == '0) ? '0 : quo_res;
      m[cj][ci] <= w_ij;
      if (w_jj == '0) dz <= 1'b1;
    end
  end

  assign o_busy     = st != IDLE;
  assign o_done     = st == DONE;
  assign o_div_zero = dz;

  always_comb begin
    o_mat = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c <= r; c++)
        o_mat[tri_idx(r, c)*DW +: DW] = m[r][c];
  end

endmodule

// File: tb/tb_ldlt_decomp_nxn.sv
// Directed bench for ldlt_decomp_nxn at N=6, N=3 and N=2.
// Hand-computed L/D results, latencies, flags and reset behaviour.
module tb_ldlt_decomp_nxn;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] dz;
  logic [21*DW-1:0] mi6 = '0;
  logic [21*DW-1:0] mo6;
  logic [6*DW-1:0]  mi3 = '0;
  logic [6*DW-1:0]  mo3;
  logic [3*DW-1:0]  mi2 = '0;
  logic [3*DW-1:0]  mo2;
  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  ldlt_decomp_nxn #(.N(6), .DW(DW), .FRAC(16)) u6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]),
    .i_mat(mi6), .o_busy(busy[0]), .o_done(done[0]),
    .o_div_zero(dz[0]), .o_mat(mo6));

  ldlt_decomp_nxn #(.N(3), .DW(DW), .FRAC(16)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]),
    .i_mat(mi3), .o_busy(busy[1]), .o_done(done[1]),
    .o_div_zero(dz[1]), .o_mat(mo3));

  ldlt_decomp_nxn #(.N(2), .DW(DW), .FRAC(16)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]),
    .i_mat(mi2), .o_busy(busy[2]), .o_done(done[2]),
    .o_div_zero(dz[2]), .o_mat(mo2));

  task automatic chk(input string tag,
                     input logic [671:0] obs,
                     input logic [671:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // identity (1.0 on diagonal) with a chosen slot-0 value
  function automatic logic [671:0] id6(input logic [31:0] d0);
    logic [671:0] v;
    v = '0;
    for (int r = 0; r < 6; r++)
      v[(r*(r+1)/2+r)*32 +: 32] = (r == 0) ? d0 : 32'h10000;
    return v;
  endfunction

  // start on an idle cycle, count edges from acceptance to o_done
  task automatic run(input int s, input int exp_t,
                     input int poke, input string tag);
    int n = 0;
    repeat (2) @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1 start[s] = 1'b0;
    while (done[s] !== 1'b1 && n < 400) begin
      start[s] = (n == poke);
      @(posedge clk);
      #1 n++;
    end
    start[s] = 1'b0;
    chk({tag, "_lat"}, n, exp_t);
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_flags", {busy, done, dz}, 9'b0);
    chk("rst_mat6", mo6, '0);
    @(negedge clk) rst_n = 1'b1;

    mi6 = id6(32'h10000);
    run(0, 166, -1, "id6");
    chk("id6_mat", mo6, id6(32'h10000));
    chk("id6_dz", dz[0], 1'b0);
    @(posedge clk);
    #1 chk("id6_pulse", {done[0], busy[0]}, 2'b00);

    mi6 = id6(32'h0);
    run(0, 166, -1, "zp6");
    chk("zp6_mat", mo6, id6(32'h0));
    chk("zp6_dz", dz[0], 1'b1);
    @(posedge clk);
    #1 chk("zp6_sticky", dz[0], 1'b1);
    mi6 = id6(32'h10000);
    run(0, 166, -1, "clr6");
    chk("clr6_dz", dz[0], 1'b0);
    chk("clr6_mat", mo6, id6(32'h10000));

    mi3 = {32'h60000, 32'h30000, 32'h20000,
           32'h50000, 32'h20000, 32'h40000};
    run(1, 25, -1, "n3");
    chk("n3_mat", mo3, {32'h40000, 32'h8000, 32'h8000,
                        32'h40000, 32'h8000, 32'h40000});
    run(1, 25, 10, "n3_poke");
    chk("n3_poke_mat", mo3, {32'h40000, 32'h8000, 32'h8000,
                             32'h40000, 32'h8000, 32'h40000});

    mi2 = {32'h0, 32'hFFFF_FFFF, 32'h20000};
    run(2, 8, -1, "rnd_div");
    chk("rnd_div_mat", mo2, {32'h0, 32'h0, 32'h20000});

    // L10=-1.5 -> -1; product -3 -> 0, so D1 stays 5
    mi2 = {32'h5, 32'h3, 32'hFFFE_0000};
    run(2, 8, -1, "rnd_mac");
    chk("rnd_mac_mat", mo2, {32'h5, 32'hFFFF_FFFF, 32'hFFFE_0000});

    mi2 = {32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    run(2, 8, -1, "rail");
`ifdef LDLT_SAT_EN
    chk("rail_mat", mo2, {32'h8000_0000, 32'h7FFF_FFFF, 32'h1});
`else
    chk("rail_mat", mo2, {32'hFFFF_FFFF, 32'hFFFF_0000, 32'h1});
`endif

    mi6 = id6(32'h10000);
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rstmid_flags", {busy, done, dz}, 9'b0);
    chk("rstmid_mat", mo6, '0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(posedge clk);
      #1 if (done[0] || busy[0]) seen++;
    end
    chk("rstmid_idle", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
